// File: rtl/energy_window_accum_if.sv
// ---------------------------------------------------------------------------
// energy_window_accum_if
// Bundles the sample stream, window control and result signals of
// energy_window_accum.
//   master : drives samples/control (i_in, q_in, in_valid, log2_len, start,
//            continuous), receives results
//   slave  : the accumulator itself; drives sum_out, shift_out, out_valid,
//            busy, overflow
// ---------------------------------------------------------------------------
interface energy_window_accum_if #(
    parameter int SAMPLE_W = 12,
    parameter int ACC_W    = 32
);
    logic signed [SAMPLE_W-1:0] i_in;
    logic signed [SAMPLE_W-1:0] q_in;
    logic                       in_valid;
    logic [4:0]                 log2_len;
    logic                       start;
    logic                       continuous;
    logic [ACC_W-1:0]           sum_out;
    logic [4:0]                 shift_out;
    logic                       out_valid;
    logic                       busy;
    logic                       overflow;

    modport master (
        output i_in, q_in, in_valid, log2_len, start, continuous,
        input  sum_out, shift_out, out_valid, busy, overflow
    );

    modport slave (
        input  i_in, q_in, in_valid, log2_len, start, continuous,
        output sum_out, shift_out, out_valid, busy, overflow
    );
endinterface

// File: rtl/energy_window_accum.sv
// ---------------------------------------------------------------------------
// energy_window_accum
// Computes I^2+Q^2 per accepted sample and sums it over a window of 2^L
// samples. The saturated window sum and its L are presented to the
// divide-by-2^L barrel shifter downstream (sum_out -> data, shift_out ->
// shift amount).
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : energy_window_accum_if.slave
//            in : i_in, q_in, in_valid, log2_len, start, continuous
//            out: sum_out, shift_out, out_valid, busy, overflow
// Pipeline: accept edge registers the energy (E0), the next edge adds it to
// the accumulator (E1). Results of a window's last sample land at E1.
// ---------------------------------------------------------------------------
module energy_window_accum #(
    parameter int SAMPLE_W = 12,
    parameter int ACC_W    = 32,
    parameter int L_MAX    = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    energy_window_accum_if.slave bus
);
    localparam int         E_W     = 2 * SAMPLE_W;
    localparam int         CNT_W   = (L_MAX > 0) ? L_MAX : 1;
    localparam logic [4:0] L_MAX_5 = 5'(L_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic [4:0]         r_len;
    logic [CNT_W-1:0]   r_cnt;

    // E0 stage: registered energy plus tags for the sample it belongs to
    logic               r_e_valid;
    logic               r_e_last;
    logic [4:0]         r_e_shift;
    logic [E_W-1:0]     r_energy;

    // E1 stage: running window accumulator
    logic [ACC_W-1:0]   r_acc;
    logic               r_sticky;
    logic               r_acc_fresh;   // next energy starts a new window: load, not add

    // Registered outputs
    logic [ACC_W-1:0]   r_sum_out;
    logic [4:0]         r_shift_out;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_overflow;

    logic [4:0]         w_len_clamped;
    logic signed [E_W-1:0] w_ii;
    logic signed [E_W-1:0] w_qq;
    logic [E_W-1:0]     w_energy;
    logic [31:0]        w_limit;
    logic               w_last;
    logic               w_accept;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W:0]     w_sum;
    logic               w_sat;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_sticky;

    assign w_len_clamped = (bus.log2_len > L_MAX_5) ? L_MAX_5 : bus.log2_len;

    // Both squares are non-negative and at most 2^(2*SAMPLE_W-2), so their
    // sum always fits in 2*SAMPLE_W unsigned bits.
    assign w_ii     = bus.i_in * bus.i_in;
    assign w_qq     = bus.q_in * bus.q_in;
    assign w_energy = $unsigned(w_ii) + $unsigned(w_qq);

    // Counter value of the last sample of the window: 2^L - 1
    assign w_limit  = (32'd1 << r_len) - 32'd1;
    assign w_last   = (32'(r_cnt) == w_limit);
    assign w_accept = (r_state == S_ACCUM) && bus.in_valid;

    // One extra carry bit detects wrap; saturate to all ones when it is set.
    assign w_base     = r_acc_fresh ? '0 : r_acc;
    assign w_sum      = {1'b0, w_base} + {{(ACC_W + 1 - E_W){1'b0}}, r_energy};
    assign w_sat      = w_sum[ACC_W];
    assign w_acc_next = w_sat ? '1 : w_sum[ACC_W-1:0];
    assign w_sticky   = (r_acc_fresh ? 1'b0 : r_sticky) | w_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_e_valid   <= 1'b0;
            r_e_last    <= 1'b0;
            r_e_shift   <= '0;
            r_energy    <= '0;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_acc_fresh <= 1'b1;
            r_sum_out   <= '0;
            r_shift_out <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_e_valid   <= w_accept;

            // E0: capture energy of the accepted sample
            if (w_accept) begin
                r_energy  <= w_energy;
                r_e_last  <= w_last;
                r_e_shift <= r_len;
            end

            // E1: fold energy into the window; the last one publishes it
            if (r_e_valid) begin
                if (r_e_last) begin
                    r_sum_out   <= w_acc_next;
                    r_shift_out <= r_e_shift;
                    r_overflow  <= w_sticky;
                    r_out_valid <= 1'b1;
                    r_acc_fresh <= 1'b1;
                    r_sticky    <= 1'b0;
                end else begin
                    r_acc       <= w_acc_next;
                    r_sticky    <= w_sticky;
                    r_acc_fresh <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_len       <= w_len_clamped;
                        r_cnt       <= '0;
                        r_acc_fresh <= 1'b1;
                        r_sticky    <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            if (bus.continuous) begin
                                // Next window follows without a gap
                                r_cnt <= '0;
                                r_len <= w_len_clamped;
                            end else begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Leave on the edge that publishes the last sample, so
                    // busy drops in the same cycle out_valid is high.
                    if (r_e_valid && r_e_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sum_out   = r_sum_out;
    assign bus.shift_out = r_shift_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_energy_window_accum.sv
module tb_energy_window_accum;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    energy_window_accum_if bus ();
    energy_window_accum dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] sum;
        logic [4:0]  shift;
        logic        ovf;
        int          t;
    } win_t;

    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;
    win_t   exp_q[$];
    win_t   obs_q[$];

    // Reference model: window bookkeeping in plain integers.
    // m_st: 0 idle, 1 collecting, 2 finishing (no new samples)
    int     m_st = 0;
    int     m_len = 0;
    longint m_cnt = 0;
    longint m_total = 0;
    int     m_end = 0;
    bit     m_busy_next = 1'b0;

    logic        s_busy, s_ovf, s_valid;
    logic [31:0] s_sum;
    logic [4:0]  s_shift;
    bit          s_busy_exp;

    // Drive one cycle: sample outputs at the falling edge, drive inputs for
    // the next rising edge and advance the model for that edge.
    task automatic step(input bit st, input bit iv, input int i, input int q,
                        input int len, input bit cont);
        win_t w;
        int   e;
        @(negedge clk);
        s_busy = bus.busy; s_sum = bus.sum_out; s_shift = bus.shift_out;
        s_ovf = bus.overflow; s_valid = bus.out_valid; s_busy_exp = m_busy_next;
        if (s_valid === 1'b1) begin
            w.sum = s_sum; w.shift = s_shift; w.ovf = s_ovf; w.t = cyc;
            obs_q.push_back(w);
        end
        bus.start = st; bus.in_valid = iv; bus.i_in = 12'(i); bus.q_in = 12'(q);
        bus.log2_len = 5'(len); bus.continuous = cont;
        cyc++;
        if (!rst_n) begin
            m_st = 0; m_busy_next = 1'b0;
        end else begin
            if (m_st == 2 && cyc > m_end) m_st = 0;
            if (m_st == 0) begin
                if (st) begin
                    m_st = 1; m_len = (len > 20) ? 20 : len; m_cnt = 0; m_total = 0;
                end
            end else if (m_st == 1 && iv) begin
                e = i * i + q * q;
                m_total += longint'(e);
                m_cnt++;
                if (m_cnt == (longint'(1) << m_len)) begin
                    w.sum   = (m_total > MAXV) ? 32'hFFFF_FFFF : m_total[31:0];
                    w.shift = 5'(m_len);
                    w.ovf   = (m_total > MAXV);
                    w.t     = cyc + 1;
                    exp_q.push_back(w);
                    if (cont) begin
                        m_len = (len > 20) ? 20 : len; m_cnt = 0; m_total = 0;
                    end else begin
                        m_st = 2; m_end = cyc + 1;
                    end
                end
            end
            m_busy_next = (m_st == 1) || (m_st == 2 && cyc < m_end);
        end
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (s_sum !== 32'd0 || s_shift !== 5'd0 || s_valid !== 1'b0 || s_busy !== 1'b0 || s_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got sum=%h shift=%0d valid=%b busy=%b ovf=%b, want all 0", s_sum, s_shift, s_valid, s_busy, s_ovf);
        end else $display("reset_state ok");
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got busy=%b valid=%b, want 0 0", s_busy, s_valid);
        end else $display("reset_release ok");
    endtask

    task automatic test_l2_basic();
        win_t o, e;
        step(1, 0, 0, 0, 2, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 3, 4, 2, 0);
        n_cmp++;
        if (s_busy !== 1'b1) begin
            n_bad++; $display("FAIL l2_busy: got busy=%b, want 1", s_busy);
        end else $display("l2_busy ok");
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 2, 0);
        n_cmp++;
        if (s_sum !== 32'd100 || s_shift !== 5'd2 || s_ovf !== 1'b0 || s_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL l2_result: got sum=%0d shift=%0d ovf=%b busy=%b, want 100 2 0 0", s_sum, s_shift, s_ovf, s_busy);
        end else $display("l2_result ok sum=%0d", s_sum);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL l2_count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o.sum !== e.sum || o.shift !== e.shift || o.ovf !== e.ovf || o.t != e.t) begin
                n_bad++;
                $display("FAIL l2_win: got sum=%h shift=%0d ovf=%b cyc=%0d, want sum=%h shift=%0d ovf=%b cyc=%0d", o.sum, o.shift, o.ovf, o.t, e.sum, e.shift, e.ovf, e.t);
            end else $display("l2_win ok sum=%h shift=%0d cyc=%0d", o.sum, o.shift, o.t);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_l0_continuous();
        win_t o, e;
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, -5, 12, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 7, -1, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_q.size() < 2 || obs_q[0].sum !== 32'd169 || obs_q[1].sum !== 32'd0 || obs_q[0].shift !== 5'd0) begin
            n_bad++; $display("FAIL l0_sums: got %0d windows first sums %0d %0d, want 169 then 0", obs_q.size(),
                              (obs_q.size() > 0) ? obs_q[0].sum : 32'd0, (obs_q.size() > 1) ? obs_q[1].sum : 32'd0);
        end else $display("l0_sums ok");
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL l0_count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o.sum !== e.sum || o.shift !== e.shift || o.ovf !== e.ovf || o.t != e.t) begin
                n_bad++;
                $display("FAIL l0_win: got sum=%h shift=%0d ovf=%b cyc=%0d, want sum=%h shift=%0d ovf=%b cyc=%0d", o.sum, o.shift, o.ovf, o.t, e.sum, e.shift, e.ovf, e.t);
            end else $display("l0_win ok sum=%h shift=%0d cyc=%0d", o.sum, o.shift, o.t);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_gapped();
        win_t o, e;
        step(1, 0, 0, 0, 3, 0);
        for (int k = 0; k < 15; k++) step((k == 5), (k % 2 == 0), 1, 1, 3, 0);
        step(1, 1, 1, 1, 3, 0);   // start and sample while finishing: ignored
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 3, 0);
        n_cmp++;
        if (s_sum !== 32'd16 || s_shift !== 5'd3 || s_busy !== 1'b0) begin
            n_bad++; $display("FAIL gap_result: got sum=%0d shift=%0d busy=%b, want 16 3 0", s_sum, s_shift, s_busy);
        end else $display("gap_result ok sum=%0d", s_sum);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL gap_count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o.sum !== e.sum || o.shift !== e.shift || o.ovf !== e.ovf || o.t != e.t) begin
                n_bad++;
                $display("FAIL gap_win: got sum=%h shift=%0d ovf=%b cyc=%0d, want sum=%h shift=%0d ovf=%b cyc=%0d", o.sum, o.shift, o.ovf, o.t, e.sum, e.shift, e.ovf, e.t);
            end else $display("gap_win ok sum=%h shift=%0d cyc=%0d", o.sum, o.shift, o.t);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        win_t o, e;
        step(1, 0, 0, 0, 10, 0);
        for (int k = 0; k < 1024; k++) step(0, 1, -2048, -2048, 10, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 10, 0);
        n_cmp++;
        if (s_sum !== 32'hFFFF_FFFF || s_ovf !== 1'b1 || s_shift !== 5'd10) begin
            n_bad++; $display("FAIL sat_result: got sum=%h ovf=%b shift=%0d, want ffffffff 1 10", s_sum, s_ovf, s_shift);
        end else $display("sat_result ok sum=%h", s_sum);
        step(1, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (s_sum !== 32'd2 || s_ovf !== 1'b0 || s_shift !== 5'd1) begin
            n_bad++; $display("FAIL sat_recover: got sum=%0d ovf=%b shift=%0d, want 2 0 1", s_sum, s_ovf, s_shift);
        end else $display("sat_recover ok sum=%0d", s_sum);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL sat_count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o.sum !== e.sum || o.shift !== e.shift || o.ovf !== e.ovf || o.t != e.t) begin
                n_bad++;
                $display("FAIL sat_win: got sum=%h shift=%0d ovf=%b cyc=%0d, want sum=%h shift=%0d ovf=%b cyc=%0d", o.sum, o.shift, o.ovf, o.t, e.sum, e.shift, e.ovf, e.t);
            end else $display("sat_win ok sum=%h ovf=%b cyc=%0d", o.sum, o.ovf, o.t);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_relatch();
        win_t o, e;
        int   sums[3];
        int   shifts[3];
        sums = '{16, 8, 8};
        shifts = '{2, 1, 1};
        step(1, 0, 0, 0, 2, 1);
        for (int k = 0; k < 8; k++) step(0, 1, 2, 0, (k < 2) ? 2 : 1, (k < 7));
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (obs_q.size() != 3) begin
            n_bad++; $display("FAIL relatch_pulses: got %0d pulses, want 3", obs_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs_q[k].sum !== 32'(sums[k]) || obs_q[k].shift !== 5'(shifts[k])) begin
                    n_bad++; $display("FAIL relatch_val%0d: got sum=%0d shift=%0d, want %0d %0d", k, obs_q[k].sum, obs_q[k].shift, sums[k], shifts[k]);
                end else $display("relatch_val%0d ok sum=%0d shift=%0d", k, obs_q[k].sum, obs_q[k].shift);
            end
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL relatch_count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o.sum !== e.sum || o.shift !== e.shift || o.ovf !== e.ovf || o.t != e.t) begin
                n_bad++;
                $display("FAIL relatch_win: got sum=%h shift=%0d ovf=%b cyc=%0d, want sum=%h shift=%0d ovf=%b cyc=%0d", o.sum, o.shift, o.ovf, o.t, e.sum, e.shift, e.ovf, e.t);
            end else $display("relatch_win ok sum=%h shift=%0d cyc=%0d", o.sum, o.shift, o.t);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0, 2, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 3, 4, 2, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.sum_out !== 32'd0 || bus.shift_out !== 5'd0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_out: got sum=%h shift=%0d valid=%b busy=%b ovf=%b, want all 0", bus.sum_out, bus.shift_out, bus.out_valid, bus.busy, bus.overflow);
        end else $display("midreset_out ok");
        m_st = 0; m_busy_next = 1'b0; obs_q.delete(); exp_q.delete();
        step(0, 1, 3, 4, 2, 0);
        step(0, 0, 0, 0, 2, 0);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 1, 0);
        step(0, 1, 1, 2, 1, 0);
        step(0, 1, 1, 2, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (s_sum !== 32'd10 || s_shift !== 5'd1 || obs_q.size() != 1) begin
            n_bad++; $display("FAIL midreset_after: got sum=%0d shift=%0d pulses=%0d, want 10 1 1", s_sum, s_shift, obs_q.size());
        end else $display("midreset_after ok sum=%0d", s_sum);
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        win_t o, e;
        bit st, iv, cont;
        int len;
        for (int c = 0; c < 800; c++) begin
            st   = ($urandom_range(0, 5) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            cont = ($urandom_range(0, 3) != 0);
            len  = $urandom_range(0, 3);
            step(st, iv, $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048, len, cont);
            n_cmp++;
            if (s_busy !== s_busy_exp) begin
                n_bad++; $display("FAIL rand_busy: cyc=%0d got busy=%b, want %b", cyc, s_busy, s_busy_exp);
            end
        end
        for (int c = 0; c < 20 && m_st == 1; c++) step(0, 1, $urandom_range(0, 100), 3, 0, 0);
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (s_busy !== s_busy_exp) begin
                n_bad++; $display("FAIL rand_busy: cyc=%0d got busy=%b, want %b", cyc, s_busy, s_busy_exp);
            end
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL rand_count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o.sum !== e.sum || o.shift !== e.shift || o.ovf !== e.ovf || o.t != e.t) begin
                n_bad++;
                $display("FAIL rand_win: got sum=%h shift=%0d ovf=%b cyc=%0d, want sum=%h shift=%0d ovf=%b cyc=%0d", o.sum, o.shift, o.ovf, o.t, e.sum, e.shift, e.ovf, e.t);
            end else $display("rand_win ok sum=%h shift=%0d cyc=%0d", o.sum, o.shift, o.t);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.i_in = '0; bus.q_in = '0;
        bus.log2_len = '0; bus.continuous = 1'b0;
        test_reset();
        test_l2_basic();
        test_l0_continuous();
        test_gapped();
        test_saturation();
        test_relatch();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/energy_window_accum.md
# energy_window_accum

Computes per-sample energy I²+Q² from a complex baseband stream and accumulates it over a window of 2^L samples. Emits the 32-bit window sum together with the shift amount L, so the downstream divide-by-2^L shifter can produce the mean energy used by the adaptive-threshold detector. It is the stage feeding the D_Factor barrel shifter: sum_out drives its data input and shift_out drives its shift-amount input.

## Interface
- SAMPLE_W, 12, signed width of each of I and Q
- ACC_W, 32, accumulator and sum_out width
- L_MAX, 20, maximum accepted log2 window length
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- i_in  input  SAMPLE_W  signed in-phase sample
- q_in  input  SAMPLE_W  signed quadrature sample
- in_valid  input  1  sample qualifier, one sample per high cycle
- log2_len  input  5  requested window length exponent L
- start  input  1  single-cycle pulse, begins a window
- continuous  input  1  when high, a new window starts immediately after each window ends
- sum_out  output  ACC_W  saturated window energy sum, held between windows
- shift_out  output  5  L used for the window in sum_out
- out_valid  output  1  one-cycle pulse, sum_out/shift_out updated
- busy  output  1  high while a window is in progress or draining
- overflow  output  1  accumulator saturated during the window in sum_out

## Operation
- Reset (rst_n low, asynchronous): state IDLE; sum_out=0, shift_out=0, out_valid=0, busy=0, overflow=0; counter, accumulator and pipeline flags cleared.
- States: IDLE, ACCUM, DRAIN.
- IDLE: in_valid ignored. start=1 latches L = min(log2_len, L_MAX), clears the counter and accumulator, and moves to ACCUM. busy=1 from the next cycle.
- ACCUM: each in_valid cycle accepts a sample and increments the counter. The accepted sample with counter = 2^L−1 is marked last. On accepting it:
  - continuous=1: counter cleared, L re-latched from log2_len, stay in ACCUM; samples on the following cycles belong to the next window, with none dropped.
  - continuous=0: go to DRAIN; later samples ignored.
- start is ignored outside IDLE.
- DRAIN: waits for the last energy to reach the accumulator, then returns to IDLE with busy=0.
- Arithmetic:
  - energy = i*i + q*q, computed signed and stored as an unsigned 2·SAMPLE_W-bit value (max 2^23 at −2048,−2048).
  - Accumulation saturates at 2^ACC_W−1 and sets a per-window sticky saturation flag.
- Output update, at the accumulator cycle of the last sample:
  - sum_out ← sat(acc + energy_last), shift_out ← window L, overflow ← the window's sticky flag, out_valid=1.
  - The accumulator and sticky flag then restart for the next window: the next window's first energy is loaded, not added.
- sum_out, shift_out and overflow hold until the next out_valid.

## Timing
- Pipeline:
  - Edge E0: sample accepted; energy registered.
  - Edge E1: energy added to the accumulator.
- For the last sample, sum_out, shift_out, overflow and out_valid are all registered at E1. out_valid is high for exactly the cycle after E1, so latency is 2 clocks from the acceptance edge.
- Back-to-back windows in continuous mode produce out_valid pulses exactly 2^L in_valid cycles apart. A last sample and a next-window first sample on consecutive cycles are both handled.
- L=0: every accepted sample is a full window. sum_out = energy, out_valid 2 cycles after each sample.
- With continuous=0, DRAIN lasts until E1; busy deasserts in the cycle out_valid is high. start is accepted in that same cycle.
- Reset mid-window: the window is discarded, all outputs go to 0 immediately, and no out_valid is produced.
- start and in_valid in the same IDLE cycle: start is taken and that sample is not counted.

## Test plan
- Reset, start with L=2, four consecutive samples (3,4) → out_valid 2 cycles after the 4th accept, sum_out=100, shift_out=2, overflow=0, busy falls.
- L=0, samples (−5,12), then (0,0) with continuous=1 → two out_valid pulses with sum_out=169 then 0, shift_out=0.
- L=3 with in_valid toggling 1010… and continuous=0, samples (1,1) → single out_valid after the 8th accept, sum_out=16. Extra samples and a start while busy are ignored.
- L=10, all samples (−2048,−2048) → true total 2^33 saturates: sum_out=0xFFFFFFFF, overflow=1. The next window of (1,0) with L=1 gives sum_out=2, overflow=0.
- continuous=1 with L=2, log2_len changed to 1 mid-window, 8 samples (2,0) → out_valid pulses: sum 16/shift 2, then 8/1, then 8/1.
- Assert rst_n low after 3 of 4 samples → outputs 0 at once. After release, start with L=1 and 2 samples (1,2) → sum_out=10.
